// File: rtl/mic_pkg.sv
// PDM microphone capture: shared defaults, FSM state type and helpers.
// Used by mic_pdm_capture and mic_clk_div.
package mic_pkg;

  localparam int DAT_WIDTH_DEF = 18;
  localparam int CLK_DIV_DEF   = 25;
  localparam int DECIM_DEF     = 64;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic mic_clk;
    logic fall;
  } div_t;

  // Ones-count over decim bits needs to represent decim itself.
  function automatic int acc_width(input int d);
    return $clog2(d + 1);
  endfunction

endpackage

// File: rtl/mic_clk_div.sv
// Microphone bit-clock divider; fall strobe marks the mic_clk 1->0 edge.
// Counter and mic_clk are held at zero whenever run is low.
module mic_clk_div
  import mic_pkg::*;
#(
  parameter int clk_div = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output div_t div
);

  localparam int DW = $clog2(clk_div);

  logic [DW-1:0] cnt;
  logic          mclk;
  logic          tc;

  assign tc = (cnt == DW'(clk_div - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      mclk <= 1'b0;
    end else if (!run) begin
      cnt  <= '0;
      mclk <= 1'b0;
    end else if (tc) begin
      cnt  <= '0;
      mclk <= ~mclk;
    end else begin
      cnt  <= cnt + DW'(1);
    end
  end

  assign div.mic_clk = mclk;
  assign div.fall    = run & tc & mclk;

endmodule

// File: rtl/mic_pdm_capture.sv
// PDM microphone capture: ones-count decimator feeding a FIFO.
// Define MIC_SIGNED_EN for a signed (2*ones - decim) sample format.
module mic_pdm_capture
  import mic_pkg::*;
#(
  parameter int dat_width = DAT_WIDTH_DEF,
  parameter int clk_div   = CLK_DIV_DEF,
  parameter int decim     = DECIM_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 mic_data,
  input  logic                 full,
  input  logic                 ovf_clr,
  output logic                 mic_clk,
  output logic [dat_width-1:0] data_out,
  output logic                 wr,
  output logic                 busy,
  output logic                 overflow
);

  localparam int AW = acc_width(decim);
  localparam int CW = $clog2(decim);

  state_t               state;
  state_t               state_nxt;
  logic                 run;
  logic [1:0]           sync;
  logic                 mic_sync;
  div_t                 div;
  logic [AW-1:0]        acc;
  logic [AW-1:0]        sum;
  logic [CW-1:0]        bit_cnt;
  logic                 last;
  logic                 done;
  logic                 drop;
  logic [dat_width-1:0] sample;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[0], mic_data};
    end
  end

  assign mic_sync = sync[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (en)  state_nxt = RUN;
      RUN:  if (!en) state_nxt = IDLE;
    endcase
  end

  // Dropping en stops the divider on the same edge the FSM leaves RUN.
  assign run  = (state == RUN) & en;
  assign busy = (state == RUN);

  mic_clk_div #(
    .clk_div (clk_div)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .div   (div)
  );

  assign mic_clk = div.mic_clk;

  assign sum  = acc + AW'(mic_sync);
  assign last = (bit_cnt == CW'(decim - 1));
  assign done = div.fall & last;
  assign drop = done & full;

  always_comb begin
    sample = dat_width'(sum);
`ifdef MIC_SIGNED_EN
    sample = (dat_width'(sum) << 1) - dat_width'(decim);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc     <= '0;
      bit_cnt <= '0;
    end else if (!run) begin
      acc     <= '0;
      bit_cnt <= '0;
    end else if (div.fall) begin
      if (last) begin
        acc     <= '0;
        bit_cnt <= '0;
      end else begin
        acc     <= sum;
        bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
      wr       <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr <= done & ~full;
      if (done) begin
        data_out <= sample;
      end
      // A drop on the same edge as a clear keeps the flag set.
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mic_pdm_capture.md
MIC_PDM_CAPTURE -- requirements
Module: mic_pdm_capture

Interface
REQ-001 SHALL have parameter dat_width, default 18, sample word width matching the downstream FIFO data width.
REQ-002 SHALL have parameter clk_div, default 25: clk cycles per mic_clk half-period, legal range >=2.
REQ-003 SHALL have parameter decim, default 64: PDM bits per sample, a power of 2 in 2..2^(dat_width-2).
REQ-004 clk  in  1  system clock; all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 en  in  1  capture enable, level.
REQ-007 mic_data  in  1  PDM bit from microphone, asynchronous to clk.
REQ-008 full  in  1  FIFO full flag.
REQ-009 ovf_clr  in  1  clears overflow, single-cycle strobe.
REQ-010 mic_clk  out  1  microphone bit clock.
REQ-011 data_out  out  dat_width  last completed sample, FIFO data_in.
REQ-012 wr  out  1  FIFO write strobe.
REQ-013 busy  out  1  high while state is RUN.
REQ-014 overflow  out  1  sticky: sample dropped because full was high.

Function
REQ-015 SHALL pass mic_data through a 2-flop synchronizer (mic_sync) before any use.
REQ-016 SHALL implement states IDLE and RUN; IDLE->RUN on the first edge with en=1, RUN->IDLE on the first edge with en=0.
REQ-017 In IDLE: mic_clk=0, divider, bit counter and accumulator held at 0.
REQ-018 In RUN: divider counts 0..clk_div-1 and toggles mic_clk at terminal count; mic_clk period = 2*clk_div clk cycles.
REQ-019 On each edge where mic_clk toggles 1->0 ("fall strobe"), SHALL add mic_sync to the accumulator and increment the bit counter.
REQ-020 Accumulator width SHALL be clog2(decim+1); no overflow possible.
REQ-021 On the fall strobe completing bit decim, SHALL load data_out with the final ones-count (including that bit), zero-extended to dat_width, and clear the accumulator and bit counter for the next window.
REQ-022 On that same edge, wr SHALL go high for exactly one cycle if full=0; if full=1, wr stays 0 and overflow sets.
REQ-023 data_out SHALL update even when the sample is dropped; it SHALL be stable while wr=1 and until the next completion.
REQ-024 Consecutive wr pulses SHALL be at least 2*clk_div*decim cycles apart; wr SHALL be a glitch-free registered output.
REQ-025 en dropped mid-window: partial accumulation discarded, mic_clk low on the next edge, no wr; re-enable starts a fresh window.
REQ-026 overflow SHALL clear on ovf_clr; if set and clear coincide, set wins.

Reset
REQ-027 reset low SHALL immediately force state=IDLE, mic_clk=0, wr=0, busy=0, overflow=0, data_out=0, synchronizer, counters and accumulator = 0.
REQ-028 Reset asserted mid-window SHALL discard the window; no wr on reset release.

Configuration
REQ-029 Macro MIC_SIGNED_EN: when defined, data_out = 2*ones - decim, two's complement, sign-extended to dat_width; when undefined, data_out = unsigned ones-count (REQ-021).

Structure
REQ-030 Shared package mic_pkg SHALL hold default dat_width/clk_div/decim constants, the IDLE/RUN state type and the accumulator width function.
REQ-031 Sub-module mic_clk_div SHALL contain the divider, the mic_clk register and the fall strobe; the top level instantiates it once.

Verification (clk_div=2, decim=8, dat_width=18)
REQ-032 Reset low, then release with en=0 -> mic_clk=0, wr=0, data_out=0, overflow=0, busy=0.
REQ-033 en=1, mic_data=1 constant, full=0 -> one wr pulse per 32 cycles, data_out=8 (signed build: 8); mic_data=0 -> 0 (signed: 0x3FFF8).
REQ-034 mic_data alternating 1,0 per mic_clk -> data_out=4 (signed: 0).
REQ-035 full=1 at completion -> wr stays 0, data_out updated, overflow=1; ovf_clr pulse -> overflow=0; ovf_clr together with a new drop -> overflow stays 1.
REQ-036 en dropped after 3 bits -> mic_clk low next cycle, no wr; en re-asserted -> first wr only after 8 full bits.
REQ-037 reset pulsed low mid-window -> all outputs 0 immediately, no wr after release until en and 8 new bits.
